// File: rtl/predictor_pkg.sv
// Shared types and counter arithmetic for the 2-bit saturating branch predictor.
package predictor_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'd0;
    localparam ctr_t WNT = 2'd1;
    localparam ctr_t WT  = 2'd2;
    localparam ctr_t ST  = 2'd3;

    // Clamps at both ends so a strongly biased branch never flips on overflow.
    function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
        ctr_t next;
        next = ctr;
        if (taken) begin
            if (ctr != ST) next = ctr + 2'd1;
        end else begin
            if (ctr != SNT) next = ctr - 2'd1;
        end
        return next;
    endfunction

endpackage

// File: rtl/pred_fifo.sv
// Synchronous FIFO holding in-flight predictions; head is visible combinationally on dout.
module pred_fifo #(
    parameter int unsigned W     = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign dout = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/predictor_ctrl.sv
// Pattern-history table plus ordered in-flight queue: predicts on request,
// trains the oldest outstanding entry on resolution.
module predictor_ctrl
    import predictor_pkg::*;
#(
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned DEPTH    = 4,
    parameter ctr_t        INIT_CTR = 2'b01
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    input  logic [IDX_W-1:0]             req_idx,
    output logic                         req_ready,
    output logic                         pred_valid,
    output logic                         pred_taken,
    input  logic                         res_valid,
    input  logic                         res_taken,
    output logic                         res_mispredict,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   inflight_cnt,
    output logic                         res_err
);

    localparam int unsigned CNT_W   = $clog2(DEPTH+1);
    localparam int unsigned ENTRIES = 1 << IDX_W;
    localparam int unsigned ENT_W   = IDX_W + 1;

    ctr_t             pht [ENTRIES];
    logic             accept;
    logic             resolve;
    logic [ENT_W-1:0] head;
    logic [IDX_W-1:0] head_idx;
    logic             head_pred;
    logic             cur_pred;

    assign req_ready = (inflight_cnt != CNT_W'(DEPTH));
    assign accept    = req_valid && req_ready && !flush;
    assign resolve   = res_valid && (inflight_cnt != '0) && !flush;
    assign cur_pred  = pht[req_idx][1];
    assign head_idx  = head[ENT_W-1:1];
    assign head_pred = head[0];

    pred_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .pop   (resolve),
        .clear (flush),
        .din   ({req_idx, cur_pred}),
        .dout  (head),
        .count (inflight_cnt)
    );

    // Prediction reads the table before this edge's update lands, giving
    // read-before-write when a request and resolve hit the same index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                pht[IDX_W'(i)] <= INIT_CTR;
            end
            pred_valid     <= 1'b0;
            pred_taken     <= 1'b0;
            res_mispredict <= 1'b0;
            res_err        <= 1'b0;
        end else begin
            if (resolve) pht[head_idx] <= sat_update(pht[head_idx], res_taken);
            pred_valid     <= accept;
            pred_taken     <= accept && cur_pred;
            res_mispredict <= resolve && (res_taken != head_pred);
            if (res_valid && !flush && (inflight_cnt == '0)) res_err <= 1'b1;
        end
    end

endmodule
